// File: rtl/fir_seq_queue.sv
// Stereo circular sample queue and sequencer feeding one FIR band filter.
// Optional build macro FIR_SEQ_ZERO_FILL_EN: start full of zeros instead of filling first.
module fir_seq_queue #(
  parameter int DEPTH  = 1021,
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic               sequencing,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out,
  output logic               seq_done,
  output logic               overrun
);

  typedef enum logic [1:0] {FILL, IDLE, LEAD, STREAM} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
`ifdef FIR_SEQ_ZERO_FILL_EN
  localparam state_t          RST_STATE = IDLE;
  localparam logic [ADDR_W:0] RST_CNT   = FULL_CNT;
`else
  localparam state_t          RST_STATE = FILL;
  localparam logic [ADDR_W:0] RST_CNT   = '0;
`endif

  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [31:0]        mem_q [DEPTH];
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]  seq_cnt_q, seq_cnt_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic               sequencing_q, sequencing_d;
  logic signed [15:0] lft_out_q, lft_out_d;
  logic signed [15:0] rght_out_q, rght_out_d;
  logic               seq_done_q, seq_done_d;
  logic               overrun_q, overrun_d;
  logic               wr_en;
  logic [31:0]        rd_word;

  assign rd_word = mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    seq_cnt_d    = seq_cnt_q;
    cnt_d        = cnt_q;
    sequencing_d = sequencing_q;
    lft_out_d    = lft_out_q;
    rght_out_d   = rght_out_q;
    seq_done_d   = 1'b0;
    overrun_d    = overrun_q;
    wr_en        = 1'b0;
    case (state_q)
      FILL, IDLE: begin
        if (wrt_smpl) begin
          wr_en    = 1'b1;
          wr_ptr_d = next_ptr(wr_ptr_q);
          if (cnt_q != FULL_CNT) cnt_d = cnt_q + 1'b1;
          // Read starts at the post-write pointer, which is the oldest entry.
          if (state_q == IDLE || cnt_q == FULL_CNT - 1'b1) begin
            state_d      = LEAD;
            sequencing_d = 1'b1;
            seq_cnt_d    = '0;
            rd_ptr_d     = next_ptr(wr_ptr_q);
          end
        end
      end
      LEAD: begin
        if (seq_cnt_q == '0) begin
          seq_cnt_d = 1'b1;
        end else begin
          state_d    = STREAM;
          seq_cnt_d  = '0;
          lft_out_d  = rd_word[31:16];
          rght_out_d = rd_word[15:0];
          rd_ptr_d   = next_ptr(rd_ptr_q);
        end
      end
      STREAM: begin
        // The first sample was loaded leaving LEAD, so the last load is one cycle early.
        if (seq_cnt_q == LAST_PTR) begin
          state_d      = IDLE;
          sequencing_d = 1'b0;
          seq_done_d   = 1'b1;
        end else begin
          lft_out_d  = rd_word[31:16];
          rght_out_d = rd_word[15:0];
          rd_ptr_d   = next_ptr(rd_ptr_q);
          seq_cnt_d  = seq_cnt_q + 1'b1;
        end
      end
      default: state_d = RST_STATE;
    endcase
    if ((state_q == LEAD || state_q == STREAM) && wrt_smpl) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST_STATE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      seq_cnt_q    <= '0;
      cnt_q        <= RST_CNT;
      sequencing_q <= 1'b0;
      lft_out_q    <= '0;
      rght_out_q   <= '0;
      seq_done_q   <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      seq_cnt_q    <= seq_cnt_d;
      cnt_q        <= cnt_d;
      sequencing_q <= sequencing_d;
      lft_out_q    <= lft_out_d;
      rght_out_q   <= rght_out_d;
      seq_done_q   <= seq_done_d;
      overrun_q    <= overrun_d;
      if (wr_en) mem_q[wr_ptr_q] <= {lft_smpl, rght_smpl};
    end
  end

  assign sequencing = sequencing_q;
  assign lft_out    = lft_out_q;
  assign rght_out   = rght_out_q;
  assign seq_done   = seq_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_seq_queue.sv
// Scoreboard bench for fir_seq_queue at DEPTH=4: stimulus queues expected windows,
// a negedge monitor checks window timing, streamed samples and seq_done.
module tb_fir_seq_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wrt_smpl = 1'b0;
  logic signed [15:0] lft_smpl = '0;
  logic signed [15:0] rght_smpl = '0;
  logic               sequencing;
  logic signed [15:0] lft_out;
  logic signed [15:0] rght_out;
  logic               seq_done;
  logic               overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int seq_len = 0;
  int start_q[$];
  int exp_q[$];

  fir_seq_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt_smpl), .lft_smpl(lft_smpl),
    .rght_smpl(rght_smpl), .sequencing(sequencing), .lft_out(lft_out),
    .rght_out(rght_out), .seq_done(seq_done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one write; when a window is expected, queue its start and the hand-computed stream.
  task automatic do_write(input int l, input bit win, input int e0, input int e1,
                          input int e2, input int e3);
    wrt_smpl  = 1'b1;
    lft_smpl  = 16'(l);
    rght_smpl = 16'(-l);
    if (win) begin
      start_q.push_back(cyc);
      exp_q.push_back(e0);
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      exp_q.push_back(e3);
    end
    @(posedge clk);
    #1;
    wrt_smpl = 1'b0;
  endtask

  always @(negedge clk) begin
    int e;
    if (!rst_n) begin
      seq_len = 0;
    end else if (sequencing) begin
      if (seq_len == 0) begin
        if (start_q.size() == 0) chk("seq_rise_unexpected", cyc, -1);
        else chk("seq_rise_cycle", cyc, start_q.pop_front() + 1);
      end
      seq_len++;
      if (seq_len >= 3) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra", lft_out, -99999);
        end else begin
          e = exp_q.pop_front();
          chk("lft_out", int'(lft_out), e);
          chk("rght_out", int'(rght_out), -e);
        end
      end
    end else begin
      chk("seq_done", int'(seq_done), (seq_len != 0) ? 1 : 0);
      if (seq_len != 0) chk("seq_len", seq_len, DEPTH + 2);
      seq_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    wait_cyc(3);
    chk("rst_sequencing", int'(sequencing), 0);
    chk("rst_lft_out", int'(lft_out), 0);
    chk("rst_rght_out", int'(rght_out), 0);
    chk("rst_seq_done", int'(seq_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    wait_cyc(5);
`ifdef FIR_SEQ_ZERO_FILL_EN
    t = cyc;
    do_write(7, 1'b1, 0, 0, 0, 7);
    wait_cyc(t + 7);
    do_write(8, 1'b1, 0, 0, 7, 8);
    wait_cyc(cyc + 10);
    chk("hold_lft_out", int'(lft_out), 8);
`else
    do_write(1, 1'b0, 0, 0, 0, 0);
    do_write(2, 1'b0, 0, 0, 0, 0);
    do_write(3, 1'b0, 0, 0, 0, 0);
    wait_cyc(cyc + 3);
    chk("fill_lft_out", int'(lft_out), 0);
    chk("fill_sequencing", int'(sequencing), 0);
    t = cyc;
    do_write(4, 1'b1, 1, 2, 3, 4);
    wait_cyc(t + 7);
    t = cyc;
    do_write(5, 1'b1, 2, 3, 4, 5);
    wait_cyc(t + 7);
    t = cyc;
    do_write(6, 1'b1, 3, 4, 5, 6);
    wait_cyc(t + 9);
    chk("hold_lft_out", int'(lft_out), 6);
    chk("pre_overrun", int'(overrun), 0);
    // Overrun: a write inside the stream is dropped and latches the flag.
    t = cyc;
    do_write(7, 1'b1, 4, 5, 6, 7);
    wait_cyc(t + 4);
    do_write(99, 1'b0, 0, 0, 0, 0);
    chk("overrun_set", int'(overrun), 1);
    wait_cyc(t + 7);
    t = cyc;
    do_write(8, 1'b1, 5, 6, 7, 8);
    wait_cyc(t + 9);
    chk("overrun_held", int'(overrun), 1);
    // Reset in the middle of a window.
    t = cyc;
    do_write(9, 1'b1, 6, 7, 8, 9);
    wait_cyc(t + 4);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_sequencing", int'(sequencing), 0);
    chk("midrst_lft_out", int'(lft_out), 0);
    chk("midrst_rght_out", int'(rght_out), 0);
    chk("midrst_overrun", int'(overrun), 0);
    wait_cyc(cyc + 2);
    rst_n = 1'b1;
    wait_cyc(cyc + 1);
    do_write(11, 1'b0, 0, 0, 0, 0);
    do_write(12, 1'b0, 0, 0, 0, 0);
    do_write(13, 1'b0, 0, 0, 0, 0);
    wait_cyc(cyc + 2);
    t = cyc;
    do_write(14, 1'b1, 11, 12, 13, 14);
    wait_cyc(t + 10);
    chk("final_hold_lft", int'(lft_out), 14);
    chk("final_hold_rght", int'(rght_out), -14);
`endif
    chk("start_q_empty", start_q.size(), 0);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_seq_queue.md
# fir_seq_queue

Stereo circular sample queue and sequencer that feeds one FIR band filter. Stores the most recent DEPTH stereo samples. On each new sample it emits a `sequencing` window and streams the stored samples, oldest to newest, one per clock, aligned with the filter's coefficient-ROM walk. It sits between the audio sample source and each FIR band instance; one instance is built per band.

## Interface
- `DEPTH`, default 1021: number of stored stereo samples, equal to the FIR tap count. Legal range 2..1024.
- `ADDR_W`, default 10: pointer width. Must satisfy 2^ADDR_W ≥ DEPTH.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `wrt_smpl` in 1: one-cycle strobe; a new stereo sample is present on the sample inputs.
- `lft_smpl` in 16: left sample, signed.
- `rght_smpl` in 16: right sample, signed.
- `sequencing` out 1: high for the whole read window; drives the FIR `sequencing` input.
- `lft_out` out 16: streamed left sample, signed, registered.
- `rght_out` out 16: streamed right sample, signed, registered.
- `seq_done` out 1: one-cycle pulse in the first cycle after `sequencing` falls.
- `overrun` out 1: sticky flag; a `wrt_smpl` arrived while busy.

## Operation
- Storage: DEPTH×32 array. Write pointer `wr_ptr`, read pointer `rd_ptr`, fill count `cnt`, which saturates at DEPTH.
- Write on `wrt_smpl` when not busy:
  - `{lft_smpl,rght_smpl}` is stored at `wr_ptr`.
  - `wr_ptr` advances and wraps from DEPTH-1 to 0.
  - `cnt` increments, saturating at DEPTH.
  - Once full, each write overwrites the oldest entry.
- States:
  - FILL: `cnt` < DEPTH. Writes accepted; no sequencing.
  - IDLE: full, waiting.
  - LEAD: 2 cycles, `sequencing` high, outputs hold.
  - STREAM: DEPTH cycles, `sequencing` high, one sample per cycle.
- Transitions:
  - FILL→LEAD on the write that makes `cnt`==DEPTH.
  - IDLE→LEAD on any accepted write.
  - LEAD→STREAM after 2 cycles.
  - STREAM→IDLE after DEPTH samples; `seq_done` pulses.
- Read order:
  - `rd_ptr` is loaded with the post-write `wr_ptr`, i.e. the oldest entry.
  - It increments with wrap each STREAM cycle.
  - The last sample streamed is always the one just written.
- Busy (LEAD/STREAM) rules:
  - `wrt_smpl` is dropped: no write, no pointer change.
  - `overrun` is set to 1 and stays set until reset.
- Outputs hold their last streamed value outside STREAM.
- No arithmetic on samples; data passes bit-exact.
- Reset mid-window: everything returns to reset state immediately.
  - `sequencing` drops asynchronously.
  - The array is cleared to 0.

## Timing
- Reset values: `sequencing`=0, `lft_out`=0, `rght_out`=0, `seq_done`=0, `overrun`=0, `wr_ptr`=0, `cnt`=0, state FILL (or IDLE, see Configuration).
- An accepted `wrt_smpl` in cycle T gives:
  - `sequencing`=1 in cycles T+1 through T+DEPTH+2 (DEPTH+2 cycles).
  - Sample k (k=0 oldest) on `lft_out`/`rght_out` in cycle T+3+k, for k=0..DEPTH-1.
  - `seq_done`=1 in cycle T+DEPTH+3 only.
- This alignment serves the FIR controller, which spends T+1 clearing and T+2 on the ROM-latency wait, then accumulates in T+3..T+DEPTH+2.
- The earliest next accepted write is cycle T+DEPTH+3. A write in that same cycle is accepted, and `sequencing` re-rises at T+DEPTH+4.
- Minimum sample spacing without overrun: DEPTH+3 clocks.

## Configuration
- `FIR_SEQ_ZERO_FILL_EN`
  - Defined: reset state is IDLE with `cnt`=DEPTH and the array zeroed. The first write sequences immediately and streams DEPTH-1 zeros followed by that sample.
  - Undefined: reset state is FILL. No `sequencing` occurs until DEPTH writes have been accepted.

## Test plan
- Reset-value check (DEPTH=4, macro undefined):
  - Stimulus: apply reset, then write 3 samples.
  - Required: all outputs 0, `sequencing` never rises.
- First window (DEPTH=4, macro undefined):
  - Stimulus: write lft 1,2,3,4 (rght = −lft), then a 4th write at cycle T.
  - Required: `sequencing` high T+1..T+6; `lft_out` 1,2,3,4 at T+3..T+6; `rght_out` −1..−4; `seq_done` at T+7.
- Wrap-around (DEPTH=4, after the first-window case):
  - Stimulus: write 5.
  - Required: stream 2,3,4,5. Then write 6; required: stream 3,4,5,6.
- Overrun (DEPTH=4):
  - Stimulus: `wrt_smpl` at T+4 inside a window.
  - Required: sample dropped, stream unchanged, `overrun`=1 and held. A write at T+7 is accepted, with `sequencing` high at T+8.
- Reset mid-window (DEPTH=4):
  - Stimulus: assert `rst_n` low at T+4.
  - Required: `sequencing`=0 and outputs 0 immediately; after release, 4 writes are needed before the next window.
- `FIR_SEQ_ZERO_FILL_EN` defined (DEPTH=4):
  - Stimulus: after reset, write 7 at T.
  - Required: `lft_out` 0,0,0,7 at T+3..T+6.
